// File: rtl/sipo_capture_reg.sv
// Serial-in/parallel-out capture register: packs N accepted bits MSB-first and
// hands the word downstream over valid/ready. Optional SIPO_PARITY_EN adds a parity output.
module sipo_capture_reg #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_in,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [N-1:0]  word,
  output logic          word_valid,
  input  logic          word_ready,
`ifdef SIPO_PARITY_EN
  output logic          parity,
`endif
  output logic [CW-1:0] bit_cnt
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [N-1:0]  word_q, word_d;
  logic          word_valid_q, word_valid_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [N-1:0]  shifted;
  logic          accept;
  logic          last_bit;

  assign s_ready  = (state_q == FILL);
  assign accept   = s_valid && s_ready;
  assign shifted  = {shreg_q[N-2:0], s_in};
  assign last_bit = (bit_cnt_q == CW'(N - 1));

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    bit_cnt_d    = bit_cnt_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          shreg_d = shifted;
          if (last_bit) begin
            word_d       = shifted;
            word_valid_d = 1'b1;
            bit_cnt_d    = '0;
            state_d      = HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        // word keeps its last value after the transfer; only the flag drops
        if (word_ready) begin
          word_valid_d = 1'b0;
          state_d      = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      shreg_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      bit_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      bit_cnt_q    <= bit_cnt_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign bit_cnt    = bit_cnt_q;

`ifdef SIPO_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (state_q == FILL && accept && last_bit) parity_d = ^shifted;
  end

  always_ff @(posedge clk) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end

  assign parity = parity_q;
`endif

endmodule
